// File: rtl/pc_return_stack.sv
// pc_return_stack
//
// Return-address stack that feeds the program counter's stack input.
// A CALL pushes the return address. A RET pops, and the PC loads TOP on
// that same edge, so it captures the entry as it was before the pop.
//
// Parameters
//   n           data width (PC address width)
//   DEPTH_LOG2  log2 of the entry count; DEPTH = 2**DEPTH_LOG2
//
// Ports
//   CLK        system clock, rising edge
//   RST        asynchronous, active-high reset
//   PUSH       write DIN as the new top entry on this edge
//   POP        discard the top entry on this edge
//   CLR_ERR    synchronous clear of OVERFLOW/UNDERFLOW
//   DIN        return address to push
//   TOP        current top entry, combinational; 0 when empty
//   COUNT      number of valid entries, 0..DEPTH
//   EMPTY      COUNT == 0
//   FULL       COUNT == DEPTH
//   OVERFLOW   sticky: push attempted while full
//   UNDERFLOW  sticky: pop attempted while empty
module pc_return_stack #(
  parameter int n          = 10,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic                  CLR_ERR,
  input  logic [n-1:0]          DIN,
  output logic [n-1:0]          TOP,
  output logic [DEPTH_LOG2:0]   COUNT,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] CNT_ONE   = {{DEPTH_LOG2{1'b0}}, 1'b1};

  logic [n-1:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   top_idx;
  logic [DEPTH_LOG2-1:0]   wr_idx;
  logic                    wr_en;
  logic                    do_replace;
  logic                    do_push;
  logic                    do_pop;
  logic                    set_overflow;
  logic                    set_underflow;

  assign EMPTY = (COUNT == '0);
  assign FULL  = (COUNT == DEPTH_CNT);

  // Index of the top entry. Working only on the low bits makes COUNT=DEPTH
  // wrap to DEPTH-1, which is exactly the top slot; the value is unused
  // when empty because TOP is forced to zero then.
  assign top_idx = COUNT[DEPTH_LOG2-1:0] - {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  // PUSH+POP together is a replace of the top entry, valid even when full.
  assign do_replace    = PUSH &  POP & ~EMPTY;
  assign do_push       = PUSH & ~POP & ~FULL;
  assign do_pop        = POP  & ~PUSH & ~EMPTY;
  assign set_overflow  = PUSH & ~POP & FULL;
  // Any pop request on an empty stack, with or without PUSH, is an underflow.
  assign set_underflow = POP & EMPTY;

  assign wr_en  = do_replace | do_push;
  assign wr_idx = do_replace ? top_idx : COUNT[DEPTH_LOG2-1:0];

  assign TOP = EMPTY ? '0 : mem[top_idx];

  // Storage is deliberately not reset; COUNT alone defines what is valid.
  // Writes are suppressed while RST is high so pending pushes are dropped.
  always_ff @(posedge CLK) begin
    if (wr_en && !RST) begin
      mem[wr_idx] <= DIN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COUNT <= '0;
    end else if (do_push) begin
      COUNT <= COUNT + CNT_ONE;
    end else if (do_pop) begin
      COUNT <= COUNT - CNT_ONE;
    end
  end

  // A new error in the same cycle as CLR_ERR wins over the clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      OVERFLOW  <= set_overflow  | (OVERFLOW  & ~CLR_ERR);
      UNDERFLOW <= set_underflow | (UNDERFLOW & ~CLR_ERR);
    end
  end

endmodule

// File: tb/tb_pc_return_stack.sv
module tb_pc_return_stack;

  localparam int N     = 10;
  localparam int DEPTH = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          PUSH = 1'b0;
  logic          POP = 1'b0;
  logic          CLR_ERR = 1'b0;
  logic [N-1:0]  DIN = '0;
  logic [N-1:0]  TOP;
  logic [4:0]    COUNT;
  logic          EMPTY, FULL, OVERFLOW, UNDERFLOW;

  // Minimal PC register: loads TOP when PC_LD=1 and PC_MUX_SEL=01.
  logic          pc_ld = 1'b0;
  logic [1:0]    pc_mux_sel = 2'b00;
  logic [N-1:0]  pc_count;

  int passed = 0;
  int total  = 0;

  // Reference model
  int  q[$];
  bit  m_ovf = 0;
  bit  m_unf = 0;

  pc_return_stack #(.n(N), .DEPTH_LOG2(4)) dut (
    .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .CLR_ERR(CLR_ERR),
    .DIN(DIN), .TOP(TOP), .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pc_count <= '0;
    else if (pc_ld && pc_mux_sel == 2'b01) pc_count <= TOP;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  function automatic int m_top();
    return (q.size() > 0) ? q[q.size()-1] : 0;
  endfunction

  task automatic chk_all(input string tag);
    chk({tag, ".count"},     32'(COUNT),     32'(q.size()));
    chk({tag, ".top"},       32'(TOP),       32'(m_top()));
    chk({tag, ".empty"},     32'(EMPTY),     32'(q.size() == 0));
    chk({tag, ".full"},      32'(FULL),      32'(q.size() == DEPTH));
    chk({tag, ".overflow"},  32'(OVERFLOW),  32'(m_ovf));
    chk({tag, ".underflow"}, 32'(UNDERFLOW), 32'(m_unf));
  endtask

  // Reference behaviour of one clock edge, from pre-edge model state.
  task automatic model_edge(input bit push, input bit pop, input bit clr, input int din);
    bit so = 0, su = 0;
    if (push && pop) begin
      if (q.size() > 0) q[q.size()-1] = din;
      else su = 1;
    end else if (push) begin
      if (q.size() < DEPTH) q.push_back(din);
      else so = 1;
    end else if (pop) begin
      if (q.size() > 0) void'(q.pop_back());
      else su = 1;
    end
    m_ovf = so | (m_ovf & !clr);
    m_unf = su | (m_unf & !clr);
  endtask

  // Inputs change at the falling edge; outputs are checked at the next one.
  task automatic step(input bit push, input bit pop, input bit clr, input int din, input string tag);
    PUSH = push; POP = pop; CLR_ERR = clr; DIN = N'(din);
    @(posedge CLK);
    model_edge(push, pop, clr, din);
    @(negedge CLK);
    PUSH = 0; POP = 0; CLR_ERR = 0;
    chk_all(tag);
  endtask

  task automatic do_reset();
    q.delete(); m_ovf = 0; m_unf = 0;
  endtask

  initial begin
    int pops[$];
    int bias;
    // Reset state
    #2;
    chk_all("reset");
    @(negedge CLK);
    RST = 0;

    // Basic LIFO
    step(1, 0, 0, 'h010, "push010");
    step(1, 0, 0, 'h020, "push020");
    step(1, 0, 0, 'h3FF, "push3ff");
    chk("basic.count3", 32'(COUNT), 3);
    chk("basic.top3ff", 32'(TOP), 'h3FF);
    step(0, 1, 0, 0, "pop1");
    chk("basic.top020", 32'(TOP), 'h020);
    step(0, 1, 0, 0, "pop2");
    chk("basic.top010", 32'(TOP), 'h010);
    step(0, 1, 0, 0, "pop3");
    chk("basic.top000", 32'(TOP), 0);
    chk("basic.empty", 32'(EMPTY), 1);

    // Fill, overflow, drain
    for (int i = 0; i < 16; i++) step(1, 0, 0, 'h100 + i, "fill");
    chk("fill.full", 32'(FULL), 1);
    chk("fill.top", 32'(TOP), 'h10F);
    step(1, 0, 0, 'h2AA, "push17");
    chk("ovf.count", 32'(COUNT), 16);
    chk("ovf.top", 32'(TOP), 'h10F);
    chk("ovf.flag", 32'(OVERFLOW), 1);
    for (int i = 15; i >= 0; i--) begin
      chk("drain.top", 32'(TOP), 'h100 + i);
      step(0, 1, 0, 0, "drain");
    end
    step(0, 0, 1, 0, "clr_ovf");
    chk("clr.ovf", 32'(OVERFLOW), 0);

    // Underflow and clear priority
    step(0, 1, 0, 0, "pop_empty");
    chk("unf.flag", 32'(UNDERFLOW), 1);
    chk("unf.top", 32'(TOP), 0);
    step(0, 0, 1, 0, "clr_unf");
    chk("unf.cleared", 32'(UNDERFLOW), 0);
    step(0, 1, 1, 0, "pop_and_clr");
    chk("unf.setwins", 32'(UNDERFLOW), 1);
    step(0, 0, 1, 0, "clr_unf2");

    // Replace
    step(1, 0, 0, 'h077, "r_push1");
    step(1, 0, 0, 'h055, "r_push2");
    step(1, 1, 0, 'h123, "replace");
    chk("repl.top", 32'(TOP), 'h123);
    chk("repl.count", 32'(COUNT), 2);
    step(0, 1, 0, 0, "repl_pop");
    chk("repl.second", 32'(TOP), 'h077);
    step(0, 1, 0, 0, "repl_pop2");
    for (int i = 0; i < 16; i++) step(1, 0, 0, 'h200 + i, "fill2");
    step(1, 1, 0, 'h3C3, "replace_full");
    chk("replfull.top", 32'(TOP), 'h3C3);
    chk("replfull.ovf", 32'(OVERFLOW), 0);
    for (int i = 0; i < 16; i++) step(0, 1, 0, 0, "drain2");
    step(1, 1, 0, 'h111, "replace_empty");
    chk("replempty.unf", 32'(UNDERFLOW), 1);
    chk("replempty.count", 32'(COUNT), 0);
    step(0, 0, 1, 0, "clr3");

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 5; i++) step(1, 0, 0, 'h040 + i, "pre_rst");
    step(0, 1, 0, 0, "pre_rst_unf_clear");
    #2;
    RST = 1;
    #1;
    do_reset();
    chk_all("async_rst");
    PUSH = 1; DIN = 'h3AA;
    @(posedge CLK);
    @(negedge CLK);
    PUSH = 0;
    chk_all("rst_hold");
    RST = 0;
    step(0, 1, 0, 0, "post_rst_pop");
    chk("postrst.unf", 32'(UNDERFLOW), 1);
    chk("postrst.top", 32'(TOP), 0);
    step(0, 0, 1, 0, "clr4");

    // CALL / RET integration with PC
    step(1, 0, 0, 'h0A1, "call");
    pc_ld = 1; pc_mux_sel = 2'b01;
    step(0, 1, 0, 0, "ret");
    pc_ld = 0; pc_mux_sel = 2'b00;
    chk("ret.pc", 32'(pc_count), 'h0A1);
    chk("ret.empty", 32'(EMPTY), 1);

    // Randomised traffic against the model
    for (int blk = 0; blk < 20; blk++) begin
      bias = $urandom_range(10, 90);
      for (int i = 0; i < 25; i++) begin
        bit p, o, c;
        p = ($urandom_range(0, 99) < bias);
        o = ($urandom_range(0, 99) >= bias) || ($urandom_range(0, 9) == 0);
        c = ($urandom_range(0, 7) == 0);
        step(p, o, c, int'($urandom_range(0, 1023)), "rand");
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
